fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester and of the FIFO write port.
REQ-002 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-003 Parameter BURST_LEN, default 4, max beats per grant (1..16).
REQ-004 w_clk  input  1  single clock, FIFO write-side clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester data-valid.
REQ-007 req_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NUM_REQ  per-requester accept; beat transfers when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-009 full  input  1  FIFO full flag, w_clk domain.
REQ-010 wr_rq  output  1  FIFO write strobe.
REQ-011 wdata  output  WIDTH  FIFO write data.
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of the current grant holder.
REQ-013 busy  output  1  high while in GRANT state.

Function
REQ-014 FSM states: IDLE, GRANT; registered state, grant_id, beat counter, last_grant.
REQ-015 IDLE: if any req_valid bit is high, select winner round-robin, searching from last_grant+1 upward with wrap modulo NUM_REQ; latch winner into grant_id, clear beat counter, go to GRANT next cycle (one-cycle arbitration latency).
REQ-016 IDLE with no req_valid: remain IDLE, grant_id unchanged.
REQ-017 req_ready[i] = (state==GRANT) and (i==grant_id) and !full; all other bits 0, combinational.
REQ-018 wr_rq = req_valid[grant_id] and req_ready[grant_id], combinational; wdata = req_data slice of grant_id, regardless of wr_rq.
REQ-019 Each accepted beat increments the beat counter by 1; counter width $clog2(BURST_LEN)+1, never wraps.
REQ-020 GRANT -> IDLE when an accepted beat brings the count to BURST_LEN, or when req_valid[grant_id] is low in GRANT; on exit last_grant <= grant_id.
REQ-021 full high in GRANT: no beat, counter frozen, grant held indefinitely; leaving GRANT does not depend on full.
REQ-022 req_valid of non-granted requesters has no effect during GRANT.
REQ-023 A requester deasserting req_valid mid-burst forfeits the rest of its burst; it competes again from IDLE with normal round-robin order.
REQ-024 Fairness: with all requesters continuously valid and full low, grants cycle 0,1,..,NUM_REQ-1,0..., each burst exactly BURST_LEN beats, one IDLE cycle between bursts.
REQ-025 wr_rq never asserts while full is high; at most one req_ready bit high per cycle.

Reset
REQ-026 While rst high: state IDLE, grant_id 0, beat counter 0, last_grant NUM_REQ-1 (requester 0 has first priority); hence req_ready 0, wr_rq 0, busy 0.
REQ-027 Reset asserted mid-burst aborts the burst immediately (asynchronous); no wr_rq until a new grant after release.
REQ-028 First arbitration occurs on the first rising edge after rst deasserts.

Verification
REQ-029 Reset, then req_valid=4'b1111, full=0, BURST_LEN=4 -> grant_id sequence 0,1,2,3,0; 4 wr_rq per burst; busy low exactly 1 cycle between bursts.
REQ-030 Only requester 2 valid, data 0xA0..0xA5 -> wdata 0xA0,0xA1,0xA2,0xA3 written, 1 IDLE cycle, then 0xA4,0xA5 in a second grant to 2.
REQ-031 Grant to 1, full asserted after 2 beats for 5 cycles -> wr_rq=0 and req_ready=0 for those 5 cycles, grant_id stays 1, remaining 2 beats complete after full drops.
REQ-032 Grant to 0, req_valid[0] drops after 1 beat while req_valid[3] high -> GRANT exits, next grant_id=3 (searching from 1), requester 0 gets no further beats in that grant.
REQ-033 rst asserted during beat 2 of a burst -> req_ready, wr_rq, busy go 0 without a clock edge; after release with all valid, first grant_id=0.
REQ-034 Random valid/full stress over 10k cycles -> scoreboard: every accepted beat appears in FIFO once, per-requester order preserved, no wr_rq while full high.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: hands the FIFO write port to one requester at a time
// for a burst of up to BURST_LEN beats, with one arbitration cycle between bursts.
module fifo_wr_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic                       w_clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       full,
   output logic                       wr_rq,
   output logic [WIDTH-1:0]           wdata,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);
   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(BURST_LEN) + 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e          state_q;
   logic [IdW-1:0]  grant_q;
   logic [IdW-1:0]  last_q;
   logic [CntW-1:0] cnt_q;
   logic [IdW-1:0]  winner;
   logic            cur_valid;

   // Walk the ring from farthest to nearest so the requester closest after
   // last_q is the final (winning) assignment.
   always_comb begin
      winner = last_q;
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         if (req_valid[(32'(last_q) + k) % NUM_REQ]) begin
            winner = IdW'((32'(last_q) + k) % NUM_REQ);
         end
      end
   end

   assign cur_valid = req_valid[grant_q];

   always_comb begin
      req_ready = '0;
      if (state_q == StGrant && !full) begin
         req_ready[grant_q] = 1'b1;
      end
   end

   assign wr_rq    = cur_valid & req_ready[grant_q];
   assign wdata    = req_data[grant_q*WIDTH +: WIDTH];
   assign grant_id = grant_q;
   assign busy     = (state_q == StGrant);

   always_ff @(posedge w_clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         grant_q <= '0;
         cnt_q   <= '0;
         last_q  <= IdW'(NUM_REQ - 1);
      end else begin
         case (state_q)
            StIdle: begin
               if (|req_valid) begin
                  grant_q <= winner;
                  cnt_q   <= '0;
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               // A dropped valid ends the grant even while the FIFO is full.
               if (!cur_valid) begin
                  state_q <= StIdle;
                  last_q  <= grant_q;
               end else if (!full) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q + 1'b1 == LastBeat) begin
                     state_q <= StIdle;
                     last_q  <= grant_q;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with fixed expectations, then a
// randomized valid/full run against a transaction-level model plus a data scoreboard.
module tb_fifo_wr_arbiter;
   localparam int unsigned W = 8;
   localparam int unsigned N = 4;
   localparam int unsigned B = 4;

   logic                   w_clk = 1'b0;
   logic                   rst;
   logic [N-1:0]           req_valid;
   logic [N*W-1:0]         req_data;
   logic [N-1:0]           req_ready;
   logic                   full;
   logic                   wr_rq;
   logic [W-1:0]           wdata;
   logic [$clog2(N)-1:0]   grant_id;
   logic                   busy;

   logic [W-1:0] base [N];
   logic [5:0]   seq  [N];
   logic         clr_seq;
   int           n_vec = 0;
   int           n_err = 0;

   always #5 w_clk = ~w_clk;

   fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_LEN(B)) dut (
      .w_clk    (w_clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .full     (full),
      .wr_rq    (wr_rq),
      .wdata    (wdata),
      .grant_id (grant_id),
      .busy     (busy)
   );

   // Requester sources: each presents base + number of beats it has had accepted.
   always @(posedge w_clk) begin
      for (int i = 0; i < N; i++) begin
         if (clr_seq) seq[i] <= '0;
         else if (req_valid[i] && req_ready[i]) seq[i] <= seq[i] + 6'd1;
      end
   end

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = base[i] + {2'b00, seq[i]};
   end

   task automatic do_reset(input logic [N-1:0] v);
      rst = 1'b1; clr_seq = 1'b1; req_valid = '0; full = 1'b0;
      repeat (2) @(posedge w_clk);
      #1 rst = 1'b0; clr_seq = 1'b0; req_valid = v;
      @(negedge w_clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; clr_seq = 1'b1; req_valid = '1; full = 1'b0;
      repeat (2) @(posedge w_clk);
      @(negedge w_clk);
      n_vec++;
      if (busy !== 1'b0 || wr_rq !== 1'b0 || req_ready !== '0 || grant_id !== '0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b wr_rq=%b ready=%b gid=%0d, want 0 0 0000 0",
                  busy, wr_rq, req_ready, grant_id);
      end
      do_reset('0);
      for (int k = 0; k < 3; k++) begin
         @(negedge w_clk);
         n_vec++;
         if (busy !== 1'b0 || grant_id !== '0) begin
            n_err++;
            $display("FAIL idle_no_valid: busy=%b gid=%0d, want 0 0", busy, grant_id);
         end
      end
   endtask

   task automatic test_fairness();
      int n, g, beat;
      logic e_busy;
      do_reset('1);
      for (int k = 0; k < 25; k++) begin
         if (k > 0) @(negedge w_clk);
         n = k / 5; g = n % N; beat = (n / N) * B + (k % 5) - 1;
         e_busy = (k % 5) != 0;
         n_vec++;
         if (busy !== e_busy || wr_rq !== e_busy ||
             (e_busy && (grant_id !== 2'(g) || wdata !== base[g] + 8'(beat)))) begin
            n_err++;
            $display("FAIL fairness_k%0d: busy=%b wr=%b gid=%0d wdata=%h, want %b %b %0d %h",
                     k, busy, wr_rq, grant_id, wdata, e_busy, e_busy, g, base[g] + 8'(beat));
         end
      end
   endtask

   task automatic test_single();
      logic [W-1:0] got [$];
      base[2] = 8'hA0;
      do_reset(4'b0100);
      for (int k = 1; k <= 11; k++) begin
         @(posedge w_clk); #1;
         req_valid = (seq[2] < 6'd6) ? 4'b0100 : 4'b0000;
         @(negedge w_clk);
         if (wr_rq === 1'b1) got.push_back(wdata);
         if (k == 5 || k == 6) begin
            n_vec++;
            if (busy !== (k == 6) || (k == 6 && grant_id !== 2'd2)) begin
               n_err++;
               $display("FAIL single_gap_k%0d: busy=%b gid=%0d, want %b 2", k, busy, grant_id,
                        k == 6);
            end
         end
      end
      n_vec++;
      if (got.size() != 6) begin
         n_err++;
         $display("FAIL single_count: got %0d writes, want 6", got.size());
      end else begin
         for (int j = 0; j < 6; j++) begin
            n_vec++;
            if (got[j] !== 8'hA0 + 8'(j)) begin
               n_err++;
               $display("FAIL single_data%0d: got %h, want %h", j, got[j], 8'hA0 + 8'(j));
            end
         end
      end
      base[2] = 8'(2 * 64);
   endtask

   task automatic test_full_stall();
      logic e_busy, e_wr;
      logic [W-1:0] e_d;
      do_reset(4'b0010);
      for (int k = 1; k <= 10; k++) begin
         @(posedge w_clk); #1;
         full = (k >= 3 && k <= 7);
         @(negedge w_clk);
         e_busy = (k != 10);
         e_wr = (k < 3) || (k == 8) || (k == 9);
         e_d = base[1] + 8'((k < 3) ? k - 1 : k - 6);
         n_vec++;
         if (busy !== e_busy || wr_rq !== e_wr || req_ready !== (e_wr ? 4'b0010 : 4'b0000) ||
             (e_busy && grant_id !== 2'd1) || (e_wr && wdata !== e_d)) begin
            n_err++;
            $display("FAIL full_stall_k%0d: busy=%b wr=%b ready=%b gid=%0d wdata=%h, want %b %b gid 1 %h",
                     k, busy, wr_rq, req_ready, grant_id, wdata, e_busy, e_wr, e_d);
         end
      end
      full = 1'b0;
   endtask

   task automatic test_forfeit();
      logic e_busy, e_wr;
      logic [1:0] e_g;
      do_reset(4'b1001);
      for (int k = 1; k <= 4; k++) begin
         @(posedge w_clk); #1;
         if (k == 2) req_valid = 4'b1000;
         @(negedge w_clk);
         e_busy = (k != 3); e_wr = (k == 1 || k == 4); e_g = (k == 4) ? 2'd3 : 2'd0;
         n_vec++;
         if (busy !== e_busy || wr_rq !== e_wr || (e_busy && grant_id !== e_g)) begin
            n_err++;
            $display("FAIL forfeit_k%0d: busy=%b wr=%b gid=%0d, want %b %b %0d",
                     k, busy, wr_rq, grant_id, e_busy, e_wr, e_g);
         end
      end
      n_vec++;
      if (seq[0] !== 6'd1) begin
         n_err++;
         $display("FAIL forfeit_beats0: requester 0 got %0d beats, want 1", seq[0]);
      end
   endtask

   task automatic test_async_reset();
      do_reset('1);
      @(posedge w_clk); @(negedge w_clk);
      @(posedge w_clk); #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (req_ready !== '0 || wr_rq !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: ready=%b wr=%b busy=%b, want 0000 0 0", req_ready, wr_rq, busy);
      end
      clr_seq = 1'b1;
      @(posedge w_clk); #1;
      rst = 1'b0; clr_seq = 1'b0;
      @(negedge w_clk);
      n_vec++;
      if (busy !== 1'b0 || wr_rq !== 1'b0) begin
         n_err++;
         $display("FAIL after_release_idle: busy=%b wr=%b, want 0 0", busy, wr_rq);
      end
      @(negedge w_clk);
      n_vec++;
      if (busy !== 1'b1 || grant_id !== 2'd0 || wr_rq !== 1'b1) begin
         n_err++;
         $display("FAIL after_release_grant: busy=%b gid=%0d wr=%b, want 1 0 1", busy, grant_id, wr_rq);
      end
   endtask

   task automatic test_random();
      logic         m_busy;
      int           m_gid, m_cnt, m_last, r;
      int           acc [N];
      int           obs [N];
      logic [5:0]   ehead [N];
      logic [N-1:0] e_ready;
      logic         e_wr;
      logic [W-1:0] e_d;
      for (int i = 0; i < N; i++) begin
         acc[i] = 0; obs[i] = 0; ehead[i] = '0; base[i] = 8'(i * 64);
      end
      do_reset('0);
      m_busy = 1'b0; m_gid = 0; m_cnt = 0; m_last = N - 1;
      for (int c = 0; c < 10000; c++) begin
         @(posedge w_clk);
         // Model reacts to the inputs held across this edge.
         if (!m_busy) begin
            if (req_valid != '0) begin
               for (int k = 1; k <= N; k++) begin
                  if (req_valid[(m_last + k) % N]) begin
                     m_gid = (m_last + k) % N;
                     break;
                  end
               end
               m_cnt = 0; m_busy = 1'b1;
            end
         end else if (!req_valid[m_gid]) begin
            m_busy = 1'b0; m_last = m_gid;
         end else if (!full) begin
            m_cnt++;
            if (m_cnt == B) begin
               m_busy = 1'b0; m_last = m_gid;
            end
         end
         #1;
         if ($urandom_range(0, 9) < 3) req_valid = N'($urandom | $urandom);
         full = ($urandom_range(0, 3) == 0);
         @(negedge w_clk);
         e_ready = (m_busy && !full) ? N'(1 << m_gid) : '0;
         e_wr = m_busy && !full && req_valid[m_gid];
         e_d = base[m_gid] + {2'b00, seq[m_gid]};
         if (e_wr) acc[m_gid]++;
         n_vec++;
         if (busy !== m_busy || grant_id !== 2'(m_gid) || req_ready !== e_ready ||
             wr_rq !== e_wr || wdata !== e_d) begin
            n_err++;
            $display("FAIL random_c%0d: busy=%b gid=%0d ready=%b wr=%b wdata=%h, want %b %0d %b %b %h",
                     c, busy, grant_id, req_ready, wr_rq, wdata, m_busy, m_gid, e_ready, e_wr, e_d);
         end
         if (wr_rq === 1'b1) begin
            r = int'(wdata[7:6]);
            n_vec++;
            if (full !== 1'b0 || wdata[5:0] !== ehead[r]) begin
               n_err++;
               $display("FAIL scoreboard_c%0d: req %0d data %h full=%b, want seq %0d full 0",
                        c, r, wdata, full, ehead[r]);
            end
            ehead[r] = ehead[r] + 6'd1;
            obs[r]++;
         end
      end
      for (int i = 0; i < N; i++) begin
         n_vec++;
         if (obs[i] != acc[i]) begin
            n_err++;
            $display("FAIL beat_total%0d: saw %0d writes, want %0d", i, obs[i], acc[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) base[i] = 8'(i * 64);
      test_reset();
      test_fairness();
      test_single();
      test_full_stall();
      test_forfeit();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
